// File: rtl/matrix_mac_engine.sv
// N x N signed matrix multiply: one MAC per cycle, results streamed out row-major with a valid/ready handshake.
// Optional build macro MATMUL_SAT_EN: saturating accumulation with a sticky per-element overflow flag on res_ovf.
module matrix_mac_engine #(
    parameter int N      = 8,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   a_wr_en,
    input  logic [2*$clog2(N)-1:0] a_wr_addr,
    input  logic [DATA_W-1:0]      a_wr_data,
    input  logic                   b_wr_en,
    input  logic [2*$clog2(N)-1:0] b_wr_addr,
    input  logic [DATA_W-1:0]      b_wr_data,
    output logic                   busy,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ACC_W-1:0]       res_data,
    output logic [$clog2(N)-1:0]   res_row,
    output logic [$clog2(N)-1:0]   res_col,
    output logic                   res_ovf,
    output logic                   done
);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    state_t state, state_next;

    logic [DATA_W-1:0] a_mem [N*N];
    logic [DATA_W-1:0] b_mem [N*N];

    logic [IW-1:0]              i_idx, j_idx, k_idx;
    logic signed [ACC_W-1:0]    acc, acc_next, base, prod_ext;
    logic signed [DATA_W-1:0]   a_op, b_op;
    logic signed [2*DATA_W-1:0] prod;
    logic                       handshake, last_k, last_elem;

    assign handshake = res_valid && res_ready;
    assign last_k    = (k_idx == LAST);
    assign last_elem = (i_idx == LAST) && (j_idx == LAST);
    assign busy      = (state != IDLE);

    // NOTE: operand memories are deliberately left out of reset so contents survive it and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (a_wr_en) a_mem[a_wr_addr] <= a_wr_data;
            if (b_wr_en) b_mem[b_wr_addr] <= b_wr_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: next state is defaulted first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = MAC;
            MAC:     if (last_k) state_next = OUT;
            OUT:     if (handshake) state_next = last_elem ? IDLE : MAC;
            default: state_next = IDLE;
        endcase
    end

    // Full-width signed product, sign-extended before it joins the running sum.
    assign a_op     = a_mem[{i_idx, k_idx}];
    assign b_op     = b_mem[{k_idx, j_idx}];
    assign prod     = (2*DATA_W)'(a_op) * (2*DATA_W)'(b_op);
    assign prod_ext = ACC_W'(prod);
    assign base     = (k_idx == '0) ? '0 : acc;

`ifdef MATMUL_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] sum_wide;
    logic                  step_ovf, acc_ovf, ovf_next;

    assign sum_wide = (ACC_W+1)'(base) + (ACC_W+1)'(prod_ext);
    assign step_ovf = (sum_wide[ACC_W] != sum_wide[ACC_W-1]);
    assign ovf_next = ((k_idx == '0) ? 1'b0 : acc_ovf) | step_ovf;

    always_comb begin
        acc_next = sum_wide[ACC_W-1:0];
        if (step_ovf) acc_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_ovf <= 1'b0;
            res_ovf <= 1'b0;
        end else if (state == MAC) begin
            acc_ovf <= ovf_next;
            if (last_k) res_ovf <= ovf_next;
        end
    end
`else
    assign acc_next = base + prod_ext;
    assign res_ovf  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_idx     <= '0;
            j_idx     <= '0;
            k_idx     <= '0;
            acc       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_row   <= '0;
            res_col   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        i_idx <= '0;
                        j_idx <= '0;
                        k_idx <= '0;
                    end
                end
                MAC: begin
                    acc   <= acc_next;
                    k_idx <= k_idx + 1'b1;   // wraps to 0 after the last term
                    if (last_k) begin
                        res_valid <= 1'b1;
                        res_data  <= acc_next;
                        res_row   <= i_idx;
                        res_col   <= j_idx;
                    end
                end
                OUT: begin
                    if (handshake) begin
                        res_valid <= 1'b0;
                        j_idx     <= j_idx + 1'b1;
                        if (j_idx == LAST) i_idx <= i_idx + 1'b1;
                        done      <= last_elem;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_mac_engine.sv
// Directed bench for matrix_mac_engine at N=4, ACC_W=32: table of operand patterns plus reset and busy-time sequences.
module tb_matrix_mac_engine;
    localparam int N      = 4;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int AW     = 4;
    localparam int NV     = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start = 1'b0;
    logic              a_wr_en = 1'b0, b_wr_en = 1'b0;
    logic [AW-1:0]     a_wr_addr = '0, b_wr_addr = '0;
    logic [DATA_W-1:0] a_wr_data = '0, b_wr_data = '0;
    logic              res_ready = 1'b0;
    logic              busy, res_valid, res_ovf, done;
    logic [ACC_W-1:0]  res_data;
    logic [1:0]        res_row, res_col;

    matrix_mac_engine #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_wr_en(a_wr_en), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data),
        .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_row(res_row), .res_col(res_col),
        .res_ovf(res_ovf), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          a_ident;    // A = identity, else every element a_val
        logic [15:0] a_val;
        bit          b_ramp;     // B[r][c] = r*4+c, else every element b_val
        logic [15:0] b_val;
        int          period;     // res_ready high one cycle in every 'period'
        bit          exp_ramp;   // expected C[r][c] = r*4+c, else exp_const everywhere
        logic [31:0] exp_const;
        logic        exp_ovf;
        int          exp_done;   // expected start-to-done cycles, 0 = not timed
    } vec_t;

    vec_t        vecs [NV];
    logic [31:0] exp_q [16];
    logic        exp_ovf_g;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                a_wr_en   = 1'b1;
                b_wr_en   = 1'b1;
                a_wr_addr = AW'(r*N + c);
                b_wr_addr = AW'(r*N + c);
                a_wr_data = v.a_ident ? ((r == c) ? 16'd1 : 16'd0) : v.a_val;
                b_wr_data = v.b_ramp ? 16'(r*N + c) : v.b_val;
                @(negedge clk);
            end
        end
        a_wr_en = 1'b0;
        b_wr_en = 1'b0;
    endtask

    task automatic set_exp(input vec_t v);
        for (int e = 0; e < 16; e++) exp_q[e] = v.exp_ramp ? 32'(e) : v.exp_const;
        exp_ovf_g = v.exp_ovf;
    endtask

    // Starts an operation at a negedge and follows it to done, checking every handshake and stall.
    task automatic run_op(input string tag, input int period, input bit noise, input int exp_done);
        int               cyc, n;
        bit               prev_stall, done_seen, rdy;
        logic [ACC_W-1:0] hold_data;
        logic [1:0]       hold_row, hold_col;
        logic             hold_ovf;
        n = 0; prev_stall = 1'b0; done_seen = 1'b0;
        hold_data = '0; hold_row = '0; hold_col = '0; hold_ovf = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done_seen && cyc < 2000) begin
            if (done) begin
                done_seen = 1'b1;
                check({tag, "_count"}, n, 16);
                if (exp_done > 0) check({tag, "_done_cyc"}, cyc, exp_done);
            end else begin
                if (prev_stall) begin
                    check({tag, "_hold_valid"}, res_valid, 1);
                    check({tag, "_hold_data"}, res_data, hold_data);
                    check({tag, "_hold_row"}, res_row, hold_row);
                    check({tag, "_hold_col"}, res_col, hold_col);
                    check({tag, "_hold_ovf"}, res_ovf, hold_ovf);
                end
                rdy = ((cyc % period) == 0);
                res_ready = rdy;
                if (noise && cyc >= 2 && cyc <= 60) begin
                    start     = (cyc % 7 == 0);
                    a_wr_en   = (cyc % 5 == 0);
                    a_wr_addr = AW'(cyc);
                    a_wr_data = 16'h7777;
                    b_wr_en   = (cyc % 3 == 0);
                    b_wr_addr = AW'(cyc + 1);
                    b_wr_data = 16'h5555;
                end else begin
                    start = 1'b0; a_wr_en = 1'b0; b_wr_en = 1'b0;
                end
                if (res_valid && rdy) begin
                    if (n < 16) begin
                        check({tag, "_data"}, res_data, exp_q[n]);
                        check({tag, "_row"}, res_row, n / 4);
                        check({tag, "_col"}, res_col, n % 4);
                        check({tag, "_ovf"}, res_ovf, exp_ovf_g);
                    end else begin
                        check({tag, "_extra_result"}, n, 15);
                    end
                    n++;
                end
                prev_stall = res_valid && !rdy;
                hold_data = res_data; hold_row = res_row; hold_col = res_col; hold_ovf = res_ovf;
                @(negedge clk);
                cyc++;
            end
        end
        res_ready = 1'b0; start = 1'b0; a_wr_en = 1'b0; b_wr_en = 1'b0;
        check({tag, "_done_seen"}, done_seen, 1);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'h0000, 1'b1, 16'h0000, 1, 1'b1, 32'h0000_0000, 1'b0, 81};
        vecs[1] = '{1'b0, 16'h0002, 1'b0, 16'hFFFD, 1, 1'b0, 32'hFFFF_FFE8, 1'b0, 81};
        vecs[2] = '{1'b1, 16'h0000, 1'b1, 16'h0000, 3, 1'b1, 32'h0000_0000, 1'b0, 0};
`ifdef MATMUL_SAT_EN
        vecs[3] = '{1'b0, 16'h8000, 1'b0, 16'h8000, 1, 1'b0, 32'h7FFF_FFFF, 1'b1, 81};
`else
        vecs[3] = '{1'b0, 16'h8000, 1'b0, 16'h8000, 1, 1'b0, 32'h0000_0000, 1'b0, 81};
`endif
        vecs[4] = '{1'b0, 16'h0003, 1'b0, 16'hFFFF, 2, 1'b0, 32'hFFFF_FFF4, 1'b0, 0};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_done", done, 0);
        check("rst_ovf", res_ovf, 0);
        check("rst_data", res_data, 0);
        check("rst_row", res_row, 0);
        check("rst_col", res_col, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < NV; t++) begin
            load(vecs[t]);
            set_exp(vecs[t]);
            run_op($sformatf("vec%0d", t), vecs[t].period, 1'b0, vecs[t].exp_done);
        end

        // Reset while element (1,2) is accumulating, then restart without reloading.
        load(vecs[0]);
        set_exp(vecs[0]);
        res_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (31) @(negedge clk);
        check("midrst_busy_before", busy, 1);
        check("midrst_data_before", res_data, 5);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", res_valid, 0);
        check("midrst_data", res_data, 0);
        check("midrst_row", res_row, 0);
        check("midrst_col", res_col, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b0;
        @(negedge clk);
        run_op("after_rst", 1, 1'b0, 81);

        // Starts and writes while busy must neither restart nor touch the operands.
        run_op("busy_noise", 1, 1'b1, 81);
        run_op("persist", 1, 1'b0, 81);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/matrix_mac_engine.md
MATRIX_MAC_ENGINE -- requirements
Module: matrix_mac_engine

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning square matrix dimension (2..64, power of 2).
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning signed two's-complement operand width.
REQ-003 The block SHALL have parameter ACC_W, default 40, meaning signed accumulator/result width (>= 2*DATA_W).
REQ-004 The block SHALL have port clk, input, 1, meaning the single rising-edge clock.
REQ-005 The block SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1, meaning the request to begin a multiply of the stored A and B.
REQ-007 The block SHALL have ports a_wr_en/b_wr_en, input, 1 each, meaning operand memory write strobes.
REQ-008 The block SHALL have ports a_wr_addr/b_wr_addr, input, 2*$clog2(N) each, meaning {row,col} write address.
REQ-009 The block SHALL have ports a_wr_data/b_wr_data, input, DATA_W each, meaning operand element data.
REQ-010 The block SHALL have port busy, output, 1, meaning the FSM is not IDLE.
REQ-011 The block SHALL have ports res_valid (output, 1) and res_ready (input, 1), meaning result stream handshake.
REQ-012 The block SHALL have port res_data, output, ACC_W, meaning C[i][j] = sum over k of A[i][k]*B[k][j].
REQ-013 The block SHALL have ports res_row/res_col, output, $clog2(N) each, meaning the index of res_data.
REQ-014 The block SHALL have port res_ovf, output, 1, meaning res_data saturated (see Configuration).
REQ-015 The block SHALL have port done, output, 1, meaning a one-cycle pulse after the final result handshake.

Function
REQ-016 The FSM SHALL have states IDLE, MAC, OUT; reset state is IDLE.
REQ-017 In IDLE, writes with a_wr_en/b_wr_en SHALL update A/B memories; writes while busy SHALL be ignored.
REQ-018 start high in IDLE SHALL move to MAC with i=j=k=0 next cycle; start while busy SHALL be ignored.
REQ-019 In MAC, each cycle SHALL perform one signed MAC: acc = (k==0 ? 0 : acc) + A[i][k]*B[k][j], then k increments.
REQ-020 After the k=N-1 MAC, the FSM SHALL go to OUT with res_valid=1 and res_data/res_row/res_col/res_ovf registered.
REQ-021 Outputs SHALL be held stable while res_valid=1 and res_ready=0.
REQ-022 A handshake (res_valid & res_ready) SHALL advance (i,j) row-major, go to MAC with k=0, and drop res_valid.
REQ-023 A handshake on element (N-1,N-1) SHALL go to IDLE and pulse done high for exactly the following cycle.
REQ-024 With res_ready tied high, done SHALL assert N*N*(N+1)+1 cycles after the start cycle.
REQ-025 Products SHALL be full 2*DATA_W signed and sign-extended to ACC_W before accumulation.
REQ-026 A/B memory contents SHALL persist across operations; only explicit writes change them.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, busy=0, res_valid=0, done=0, res_ovf=0, res_data=0, res_row=0, res_col=0, including mid-operation.
REQ-028 Operand memories SHALL NOT be reset; after reset a new start SHALL require no reload if contents are intended.

Configuration
REQ-029 With MATMUL_SAT_EN defined, each accumulation SHALL saturate to signed ACC_W max/min and set a sticky per-element overflow flag presented on res_ovf.
REQ-030 Without MATMUL_SAT_EN, accumulation SHALL wrap modulo 2^ACC_W and res_ovf SHALL be constant 0.

Verification
REQ-031 N=4: A=identity, B[r][c]=r*4+c, res_ready=1 -> results 0..15 in row-major order, done at start+81 cycles.
REQ-032 N=4: A all 2, B all -3 -> every res_data = -24 (sign-extended to ACC_W), res_ovf=0.
REQ-033 N=4, res_ready toggled 1-of-3 cycles -> identical result sequence to REQ-031, outputs stable while stalled.
REQ-034 N=4, ACC_W=32, A=B all -32768, MATMUL_SAT_EN -> res_data=0x7FFFFFFF, res_ovf=1; without macro -> res_data=0x00000000, res_ovf=0.
REQ-035 rst_n low during MAC of element (1,2) -> busy=0, res_valid=0 same cycle; next start rewrites full result set correctly from (0,0).
REQ-036 start pulsed and writes issued while busy -> no restart, memories unchanged, results match pre-start A/B.
